level_sequencer: RTL
====================

// Module: level_sequencer
// PURPOSE
//  Top-level game controller that sequences the level instances: title/idle, level load, play,
//  win/lose banner, game-over and game-complete. Drives one active-low reset per level instance
//  and a level_select index for the external VGA/LED output mux. Consumes each level's win/lose.
//  Owns the lives counter and the level advance policy.
// PARAMETERS
//  NUM_LEVELS     3    number of level instances sequenced (>=1)
//  LIVES_INIT     3    lives at game start (1..15)
//  BANNER_FRAMES  120  frame_tick pulses the WON/LOST banner state is held (>=1)
//  RESET_HOLD     4    vga_clock cycles a level is held in reset during LOAD (>=1)
// PORTS
//  vga_clock      in   1               clock
//  reset          in   1               asynchronous, active-low
//  start_button   in   1               level, already synchronised; rising edge = start/restart
//  frame_tick     in   1               1-cycle pulse once per frame (end of active video)
//  level_win      in   NUM_LEVELS      win flag from each level instance
//  level_lose     in   NUM_LEVELS      lose flag from each level instance
//  level_reset_n  out  NUM_LEVELS      active-low reset to each level instance
//  level_select   out  $clog2(NUM_LEVELS) (min 1)  index of the active level
//  lives          out  4               remaining lives
//  state          out  3               0 IDLE,1 LOAD,2 PLAY,3 WON,4 LOST,5 GAMEOVER,6 COMPLETE
// BEHAVIOUR
//  Reset (async): state=IDLE, level_select=0, lives=LIVES_INIT, level_reset_n=all 0, counters=0,
//   start edge register=1 (a button held through reset does not start a game).
//  start_edge = start_button & ~start_q; start_q registered every cycle.
//  level_reset_n[i]=1 only when i==level_select and state in {PLAY,WON,LOST}; all else 0. Registered.
//  IDLE: start_edge -> LOAD.
//  LOAD: hold_cnt counts 0..RESET_HOLD-1; exit to PLAY the cycle hold_cnt==RESET_HOLD-1
//   (exactly RESET_HOLD cycles in LOAD); hold_cnt clears on exit.
//  PLAY: only level_win/lose[level_select] sampled; other bits ignored.
//   win -> WON; else lose -> LOST and lives<=lives-1 (saturating at 0). Win has priority if same cycle.
//  WON/LOST: level keeps running (reset_n stays 1); win/lose ignored; frame_cnt increments on
//   frame_tick; on the frame_tick that makes frame_cnt==BANNER_FRAMES, frame_cnt<=0 and exit:
//   WON: level_select==NUM_LEVELS-1 -> COMPLETE; else level_select+1, -> LOAD.
//   LOST: lives==0 -> GAMEOVER; else -> LOAD (same level_select).
//  GAMEOVER/COMPLETE: start_edge -> LOAD with level_select=0, lives=LIVES_INIT.
//  start_edge ignored in LOAD/PLAY/WON/LOST. frame_tick ignored outside WON/LOST.
//  Level flags are sticky in level instances; LOAD reset is what clears them before PLAY.
//  Latency: win/lose at cycle N -> state change visible N+1; level_reset_n follows one cycle later.
//  Unused state encodings (7) -> IDLE next cycle.
// TESTING
//  (bench params NUM_LEVELS=2, LIVES_INIT=2, BANNER_FRAMES=3, RESET_HOLD=4)
//  Start after reset: start_button rises -> LOAD 4 cycles, PLAY, level_reset_n=2'b01, select=0.
//  Button held through reset release -> stays IDLE until released and pressed again.
//  win[0] in PLAY -> WON; 3 frame_ticks -> LOAD, select=1; win[1] -> WON -> COMPLETE after 3 ticks.
//  lose twice on level 0 -> lives 2->1->0, second banner ends in GAMEOVER; start -> lives=2, select=0.
//  win[0]&lose[0] same cycle -> WON, lives unchanged; lose[1] while select=0 -> no effect.
//  Async reset asserted mid-WON banner -> immediate IDLE, level_reset_n=0, lives=2, select=0.

Source files
------------

// File: rtl/level_sequencer.sv
// Game controller: walks the player through the level instances, holds each level in reset
// while it loads, shows win/lose banners, and owns the lives counter and level advance policy.
module level_sequencer #(
  parameter int NUM_LEVELS    = 3,
  parameter int LIVES_INIT    = 3,
  parameter int BANNER_FRAMES = 120,
  parameter int RESET_HOLD    = 4,
  localparam int SEL_W        = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic                  vga_clock,
  input  logic                  reset,
  input  logic                  start_button,
  input  logic                  frame_tick,
  input  logic [NUM_LEVELS-1:0] level_win,
  input  logic [NUM_LEVELS-1:0] level_lose,
  output logic [NUM_LEVELS-1:0] level_reset_n,
  output logic [SEL_W-1:0]      level_select,
  output logic [3:0]            lives,
  output logic [2:0]            state
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int FRM_W  = (BANNER_FRAMES > 1) ? $clog2(BANNER_FRAMES) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BANNER_FRAMES - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_LEVELS - 1);
  localparam logic [3:0]        LIVES_RST = 4'(LIVES_INIT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_PLAY     = 3'd2,
    S_WON      = 3'd3,
    S_LOST     = 3'd4,
    S_GAMEOVER = 3'd5,
    S_COMPLETE = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [3:0]              lives_q, lives_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [FRM_W-1:0]        frame_q, frame_d;
  logic                    start_q;
  logic [NUM_LEVELS-1:0]   rstn_q, rstn_d;
  logic                    start_edge;
  logic                    win_sel, lose_sel;

  assign start_edge = start_button & ~start_q;
  assign win_sel    = level_win[sel_q];
  assign lose_sel   = level_lose[sel_q];

  // start_q resets high so a button held through reset cannot start a game
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      lives_q <= LIVES_RST;
      hold_q  <= '0;
      frame_q <= '0;
      start_q <= 1'b1;
      rstn_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      lives_q <= lives_d;
      hold_q  <= hold_d;
      frame_q <= frame_d;
      start_q <= start_button;
      rstn_q  <= rstn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    lives_d = lives_q;
    hold_d  = hold_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_PLAY;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_PLAY: begin
        if (win_sel) begin
          state_d = S_WON;
        end else if (lose_sel) begin
          state_d = S_LOST;
          if (lives_q != '0) lives_d = lives_q - 4'd1;
        end
      end
      S_WON, S_LOST: begin
        if (frame_tick) begin
          if (frame_q == FRM_LAST) begin
            frame_d = '0;
            if (state_q == S_WON) begin
              if (sel_q == SEL_LAST) begin
                state_d = S_COMPLETE;
              end else begin
                sel_d   = sel_q + 1'b1;
                state_d = S_LOAD;
              end
            end else begin
              state_d = (lives_q == '0) ? S_GAMEOVER : S_LOAD;
            end
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      S_GAMEOVER, S_COMPLETE: begin
        if (start_edge) begin
          state_d = S_LOAD;
          sel_d   = '0;
          lives_d = LIVES_RST;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Level reset follows the registered state, so it lags a state change by one cycle
  always_comb begin
    rstn_d = '0;
    if (state_q == S_PLAY || state_q == S_WON || state_q == S_LOST) rstn_d[sel_q] = 1'b1;
  end

  assign level_reset_n = rstn_q;
  assign level_select  = sel_q;
  assign lives         = lives_q;
  assign state         = state_q;

endmodule
